// File: rtl/estagio_decode_pkg.sv
`default_nettype none
// ============================================================================
// Module   : estagio_decode_pkg
// Purpose  : Shared constants and types for the decode stage: opcode and
//            funct codes, alu_op encodings, the NOP word and the control word.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package estagio_decode_pkg;

  localparam logic [31:0] c_NOP = 32'h0000_0000;

  // Primary opcodes
  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_J     = 6'b000010;
  localparam logic [5:0] c_OP_JAL   = 6'b000011;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_BNE   = 6'b000101;
  localparam logic [5:0] c_OP_ADDI  = 6'b001000;
  localparam logic [5:0] c_OP_SLTI  = 6'b001010;
  localparam logic [5:0] c_OP_ANDI  = 6'b001100;
  localparam logic [5:0] c_OP_ORI   = 6'b001101;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;

  // R-type funct codes (consumed by the execute stage ALU control)
  localparam logic [5:0] c_FUNCT_SLL = 6'b000000;
  localparam logic [5:0] c_FUNCT_JR  = 6'b001000;
  localparam logic [5:0] c_FUNCT_ADD = 6'b100000;
  localparam logic [5:0] c_FUNCT_SUB = 6'b100010;
  localparam logic [5:0] c_FUNCT_AND = 6'b100100;
  localparam logic [5:0] c_FUNCT_OR  = 6'b100101;
  localparam logic [5:0] c_FUNCT_SLT = 6'b101010;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'b00,  // address calc / addi
    ALU_BRANCH = 2'b01,  // subtract for compare
    ALU_RTYPE  = 2'b10,  // look at funct
    ALU_IMM    = 2'b11   // immediate logic / slti
  } alu_op_t;

  typedef struct packed {
    logic    reg_dst;
    logic    alu_src;
    logic    mem_to_reg;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    link;
    logic    jump;
    logic    branch;
    logic    branch_ne;
    alu_op_t alu_op;
    logic    ilegal;
  } ctrl_t;

  localparam ctrl_t c_CTRL_ZERO = '{default: '0, alu_op: ALU_ADD};

  // Logical immediates are zero-extended; everything else sign-extends.
  function automatic logic is_zero_ext(input logic [5:0] opcode);
    return (opcode == c_OP_ANDI) || (opcode == c_OP_ORI);
  endfunction

endpackage
`default_nettype wire

// File: rtl/estagio_decode_unidade_controle.sv
`default_nettype none
// ============================================================================
// Module   : unidade_controle
// Purpose  : Combinational opcode -> control word decoder, including the
//            illegal-opcode flag. Every output is forced to 0 when the ID
//            register does not hold a live instruction.
// Ports    : i_valid, i_opcode[5:0] in; control bits, o_alu_op[1:0],
//            o_ilegal out.
// Revision : 1.0 - initial release
// ============================================================================
module unidade_controle
  import estagio_decode_pkg::*;
(
  input  logic       i_valid,
  input  logic [5:0] i_opcode,
  output logic       o_reg_dst,
  output logic       o_alu_src,
  output logic       o_mem_to_reg,
  output logic       o_reg_write,
  output logic       o_mem_read,
  output logic       o_mem_write,
  output logic       o_link,
  output logic       o_jump,
  output logic       o_branch,
  output logic       o_branch_ne,
  output logic [1:0] o_alu_op,
  output logic       o_ilegal
);

  ctrl_t w_ctrl;

  always_comb begin
    w_ctrl = c_CTRL_ZERO;
    if (i_valid) begin
      unique case (i_opcode)
        c_OP_RTYPE: begin
          w_ctrl.reg_dst   = 1'b1;
          w_ctrl.reg_write = 1'b1;
          w_ctrl.alu_op    = ALU_RTYPE;
        end
        c_OP_LW: begin
          w_ctrl.alu_src    = 1'b1;
          w_ctrl.mem_to_reg = 1'b1;
          w_ctrl.reg_write  = 1'b1;
          w_ctrl.mem_read   = 1'b1;
          w_ctrl.alu_op     = ALU_ADD;
        end
        c_OP_SW: begin
          w_ctrl.alu_src   = 1'b1;
          w_ctrl.mem_write = 1'b1;
          w_ctrl.alu_op    = ALU_ADD;
        end
        c_OP_BEQ: begin
          w_ctrl.branch = 1'b1;
          w_ctrl.alu_op = ALU_BRANCH;
        end
        c_OP_BNE: begin
          w_ctrl.branch    = 1'b1;
          w_ctrl.branch_ne = 1'b1;
          w_ctrl.alu_op    = ALU_BRANCH;
        end
        c_OP_ADDI: begin
          w_ctrl.alu_src   = 1'b1;
          w_ctrl.reg_write = 1'b1;
          w_ctrl.alu_op    = ALU_ADD;
        end
        c_OP_SLTI, c_OP_ANDI, c_OP_ORI: begin
          w_ctrl.alu_src   = 1'b1;
          w_ctrl.reg_write = 1'b1;
          w_ctrl.alu_op    = ALU_IMM;
        end
        c_OP_J: begin
          w_ctrl.jump = 1'b1;
        end
        c_OP_JAL: begin
          w_ctrl.jump      = 1'b1;
          w_ctrl.link      = 1'b1;
          w_ctrl.reg_write = 1'b1;
        end
        default: begin
          w_ctrl.ilegal = 1'b1;
        end
      endcase
    end
  end

  assign o_reg_dst    = w_ctrl.reg_dst;
  assign o_alu_src    = w_ctrl.alu_src;
  assign o_mem_to_reg = w_ctrl.mem_to_reg;
  assign o_reg_write  = w_ctrl.reg_write;
  assign o_mem_read   = w_ctrl.mem_read;
  assign o_mem_write  = w_ctrl.mem_write;
  assign o_link       = w_ctrl.link;
  assign o_jump       = w_ctrl.jump;
  assign o_branch     = w_ctrl.branch;
  assign o_branch_ne  = w_ctrl.branch_ne;
  assign o_alu_op     = w_ctrl.alu_op;
  assign o_ilegal     = w_ctrl.ilegal;

endmodule
`default_nettype wire

// File: rtl/estagio_decode.sv
`default_nettype none
// ============================================================================
// Module   : estagio_decode
// Purpose  : IF/ID pipeline register plus instruction decoder. Latches the
//            fetched instruction and PC+4, splits fields, generates the
//            control word and the jump/branch targets, and squashes the
//            sequential-path instruction fetched alongside a taken jump.
// Ports    : clk, reset (async, active-high)
//            in : i_if_valid, i_if_instrucao[31:0], i_if_pc4[31:0],
//                 i_stall, i_flush
//            out: o_if_ready, o_id_valid, o_id_instrucao, o_id_pc4,
//                 instruction fields, o_imm_ext, o_jump/o_branch/o_branch_ne,
//                 o_jump_target, o_branch_target, control word, o_ilegal,
//                 o_cont_instr
// Revision : 1.0 - initial release
// ============================================================================
module estagio_decode
  import estagio_decode_pkg::*;
#(
  parameter logic [31:0] NOP = c_NOP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_if_valid,
  input  logic [31:0] i_if_instrucao,
  input  logic [31:0] i_if_pc4,
  output logic        o_if_ready,
  input  logic        i_stall,
  input  logic        i_flush,
  output logic        o_id_valid,
  output logic [31:0] o_id_instrucao,
  output logic [31:0] o_id_pc4,
  output logic [5:0]  o_opcode,
  output logic [4:0]  o_rs,
  output logic [4:0]  o_rt,
  output logic [4:0]  o_rd,
  output logic [4:0]  o_shamt,
  output logic [5:0]  o_funct,
  output logic [31:0] o_imm_ext,
  output logic        o_jump,
  output logic        o_branch,
  output logic        o_branch_ne,
  output logic [31:0] o_jump_target,
  output logic [31:0] o_branch_target,
  output logic        o_reg_dst,
  output logic        o_alu_src,
  output logic        o_mem_to_reg,
  output logic        o_reg_write,
  output logic        o_mem_read,
  output logic        o_mem_write,
  output logic        o_link,
  output logic [1:0]  o_alu_op,
  output logic        o_ilegal,
  output logic [31:0] o_cont_instr
);

  logic        r_id_valid;
  logic [31:0] r_id_instr;
  logic [31:0] r_id_pc4;
  logic [31:0] r_cont;

  logic        w_jump;
  logic        w_squash;
  logic [31:0] w_imm_ext;

  // A valid jump in ID means fetch is redirecting at this edge, so whatever
  // fetch presents now is on the fall-through path and must not go live.
  assign w_squash   = r_id_valid & w_jump;
  assign o_if_ready = ~i_stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_id_valid <= 1'b0;
      r_id_instr <= NOP;
      r_id_pc4   <= 32'h0;
    end else if (i_flush) begin
      // Flush overrides both stall and capture.
      r_id_valid <= 1'b0;
      r_id_instr <= NOP;
    end else if (!i_stall) begin
      r_id_valid <= i_if_valid & ~w_squash;
      r_id_instr <= w_squash ? NOP : i_if_instrucao;
      r_id_pc4   <= i_if_pc4;
    end
  end

  // Retired = the live instruction in ID advanced this edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cont <= 32'h0;
    end else if (r_id_valid && !i_stall && !i_flush) begin
      r_cont <= r_cont + 32'd1;
    end
  end

  unidade_controle u_unidade_controle (
    .i_valid      (r_id_valid),
    .i_opcode     (r_id_instr[31:26]),
    .o_reg_dst    (o_reg_dst),
    .o_alu_src    (o_alu_src),
    .o_mem_to_reg (o_mem_to_reg),
    .o_reg_write  (o_reg_write),
    .o_mem_read   (o_mem_read),
    .o_mem_write  (o_mem_write),
    .o_link       (o_link),
    .o_jump       (w_jump),
    .o_branch     (o_branch),
    .o_branch_ne  (o_branch_ne),
    .o_alu_op     (o_alu_op),
    .o_ilegal     (o_ilegal)
  );

  assign w_imm_ext = is_zero_ext(r_id_instr[31:26])
                   ? {16'h0000, r_id_instr[15:0]}
                   : {{16{r_id_instr[15]}}, r_id_instr[15:0]};

  assign o_id_valid      = r_id_valid;
  assign o_id_instrucao  = r_id_instr;
  assign o_id_pc4        = r_id_pc4;
  assign o_opcode        = r_id_instr[31:26];
  assign o_rs            = r_id_instr[25:21];
  assign o_rt            = r_id_instr[20:16];
  assign o_rd            = r_id_instr[15:11];
  assign o_shamt         = r_id_instr[10:6];
  assign o_funct         = r_id_instr[5:0];
  assign o_imm_ext       = w_imm_ext;
  assign o_jump          = w_jump;
  assign o_jump_target   = {r_id_pc4[31:28], r_id_instr[25:0], 2'b00};
  assign o_branch_target = r_id_pc4 + {w_imm_ext[29:0], 2'b00};
  assign o_cont_instr    = r_cont;

endmodule
`default_nettype wire

// File: tb/tb_estagio_decode.sv
`default_nettype none
// ============================================================================
// Module   : tb_estagio_decode
// Purpose  : Directed self-checking bench for estagio_decode.
// Revision : 1.0 - initial release
// ============================================================================
module tb_estagio_decode;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_valid;
  logic [31:0] if_instrucao;
  logic [31:0] if_pc4;
  logic        if_ready;
  logic        stall;
  logic        flush;
  logic        id_valid;
  logic [31:0] id_instrucao;
  logic [31:0] id_pc4;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;
  logic [31:0] imm_ext;
  logic        jump, branch, branch_ne;
  logic [31:0] jump_target, branch_target;
  logic        reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, link;
  logic [1:0]  alu_op;
  logic        ilegal;
  logic [31:0] cont_instr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  estagio_decode #(.NOP(32'h0000_0000)) dut (
    .clk             (clk),
    .reset           (reset),
    .i_if_valid      (if_valid),
    .i_if_instrucao  (if_instrucao),
    .i_if_pc4        (if_pc4),
    .o_if_ready      (if_ready),
    .i_stall         (stall),
    .i_flush         (flush),
    .o_id_valid      (id_valid),
    .o_id_instrucao  (id_instrucao),
    .o_id_pc4        (id_pc4),
    .o_opcode        (opcode),
    .o_rs            (rs),
    .o_rt            (rt),
    .o_rd            (rd),
    .o_shamt         (shamt),
    .o_funct         (funct),
    .o_imm_ext       (imm_ext),
    .o_jump          (jump),
    .o_branch        (branch),
    .o_branch_ne     (branch_ne),
    .o_jump_target   (jump_target),
    .o_branch_target (branch_target),
    .o_reg_dst       (reg_dst),
    .o_alu_src       (alu_src),
    .o_mem_to_reg    (mem_to_reg),
    .o_reg_write     (reg_write),
    .o_mem_read      (mem_read),
    .o_mem_write     (mem_write),
    .o_link          (link),
    .o_alu_op        (alu_op),
    .o_ilegal        (ilegal),
    .o_cont_instr    (cont_instr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic v, input logic [31:0] ins, input logic [31:0] pc4);
    if_valid     = v;
    if_instrucao = ins;
    if_pc4       = pc4;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    feed(1'b0, 32'hDEAD_BEEF, 32'h0);
    #12;
    check("rst_id_valid", id_valid, 0);
    check("rst_cont", cont_instr, 0);
    check("rst_instr", id_instrucao, 32'h0);
    check("rst_pc4", id_pc4, 32'h0);
    check("rst_if_ready", if_ready, 1);
    check("rst_reg_write", reg_write, 0);
    @(negedge clk);
    reset = 1'b0;

    // lw $2, 4($1)
    feed(1'b1, 32'h8C22_0004, 32'h04);
    step();
    check("lw_valid", id_valid, 1);
    check("lw_alu_src", alu_src, 1);
    check("lw_mem_read", mem_read, 1);
    check("lw_mem_to_reg", mem_to_reg, 1);
    check("lw_reg_write", reg_write, 1);
    check("lw_imm", imm_ext, 32'h4);
    check("lw_rs", rs, 1);
    check("lw_rt", rt, 2);
    check("lw_alu_op", alu_op, 2'b00);
    check("lw_cont", cont_instr, 0);

    // beq with offset -1
    feed(1'b1, 32'h1000_FFFF, 32'h10);
    step();
    check("beq_branch", branch, 1);
    check("beq_bne", branch_ne, 0);
    check("beq_target", branch_target, 32'h0C);
    check("beq_imm", imm_ext, 32'hFFFF_FFFF);
    check("beq_alu_op", alu_op, 2'b01);
    check("beq_cont", cont_instr, 1);

    // andi: zero-extended immediate
    feed(1'b1, 32'h3000_FFFF, 32'h14);
    step();
    check("andi_imm", imm_ext, 32'h0000_FFFF);
    check("andi_alu_op", alu_op, 2'b11);
    check("andi_reg_write", reg_write, 1);
    check("andi_cont", cont_instr, 2);

    // j 0x100, followed by a sequential instruction that must be squashed
    feed(1'b1, 32'h0800_0040, 32'h24);
    step();
    check("j_jump", jump, 1);
    check("j_target", jump_target, 32'h100);
    check("j_reg_write", reg_write, 0);
    check("j_cont", cont_instr, 3);
    feed(1'b1, 32'h2001_0005, 32'h28);
    step();
    check("sq_valid", id_valid, 0);
    check("sq_instr", id_instrucao, 32'h0);
    check("sq_jump", jump, 0);
    check("sq_cont", cont_instr, 4);
    // ori $3, $0, 7
    feed(1'b1, 32'h3403_0007, 32'h2C);
    step();
    check("ori_valid", id_valid, 1);
    check("ori_imm", imm_ext, 32'h7);
    check("ori_cont", cont_instr, 4);

    // stall for 3 cycles with changing input
    stall = 1'b1;
    #1;
    check("stall_ready", if_ready, 0);
    for (int k = 0; k < 3; k++) begin
      feed(1'b1, 32'h0000_1000 + k, 32'h100 + 4 * k);
      step();
      check("stall_instr", id_instrucao, 32'h3403_0007);
      check("stall_pc4", id_pc4, 32'h2C);
      check("stall_cont", cont_instr, 4);
      check("stall_ready_hold", if_ready, 0);
    end
    @(negedge clk);
    stall = 1'b0;
    feed(1'b1, 32'hAC22_0008, 32'h30);  // sw
    step();
    check("sw_instr", id_instrucao, 32'hAC22_0008);
    check("sw_mem_write", mem_write, 1);
    check("sw_reg_write", reg_write, 0);
    check("sw_cont", cont_instr, 5);

    // flush together with stall
    flush = 1'b1; stall = 1'b1;
    feed(1'b1, 32'h0022_1820, 32'h34);
    step();
    check("fs_valid", id_valid, 0);
    check("fs_instr", id_instrucao, 32'h0);
    check("fs_mem_write", mem_write, 0);
    check("fs_alu_src", alu_src, 0);
    check("fs_cont", cont_instr, 5);
    flush = 1'b0; stall = 1'b0;

    // illegal opcode 111111
    feed(1'b1, 32'hFC00_0000, 32'h38);
    step();
    check("il_ilegal", ilegal, 1);
    check("il_reg_write", reg_write, 0);
    check("il_cont", cont_instr, 5);

    // jal, then flush while it sits in ID
    feed(1'b1, 32'h0C00_0010, 32'h40);
    step();
    check("jal_jump", jump, 1);
    check("jal_link", link, 1);
    check("jal_reg_write", reg_write, 1);
    check("jal_target", jump_target, 32'h40);
    check("jal_ilegal", ilegal, 0);
    check("jal_cont", cont_instr, 6);
    flush = 1'b1;
    feed(1'b1, 32'h2001_0005, 32'h44);
    step();
    check("fj_valid", id_valid, 0);
    check("fj_cont", cont_instr, 6);
    flush = 1'b0;

    // R-type add $3,$1,$2
    feed(1'b1, 32'h0022_1820, 32'h48);
    step();
    check("r_reg_dst", reg_dst, 1);
    check("r_alu_op", alu_op, 2'b10);
    check("r_rd", rd, 3);
    check("r_funct", funct, 6'h20);
    check("r_cont", cont_instr, 6);

    // bne forward by 2
    feed(1'b1, 32'h1422_0002, 32'h50);
    step();
    check("bne_branch", branch, 1);
    check("bne_ne", branch_ne, 1);
    check("bne_target", branch_target, 32'h58);
    check("bne_cont", cont_instr, 7);

    // async reset mid-cycle while valid
    #2;
    reset = 1'b1;
    #1;
    check("ar_valid", id_valid, 0);
    check("ar_cont", cont_instr, 0);
    check("ar_branch", branch, 0);
    check("ar_pc4", id_pc4, 32'h0);
    check("ar_instr", id_instrucao, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    feed(1'b0, 32'h0, 32'h0);
    step();
    check("post_valid", id_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/estagio_decode.md
# estagio_decode

IF/ID pipeline register and instruction decoder sitting directly downstream of the fetch stage. It latches the fetched instruction and its PC+4, splits the instruction into fields, and generates the main control word. It feeds `jump`, `branch` and target addresses back to fetch, squashing the wrong-path instruction after a jump. Consumers are the register file, the execute stage and the PC-select logic.

## Interface
- `NOP`, default 32'h0000_0000: value loaded into the instruction register on reset and on squash.
- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-high.
- `if_valid` in 1: fetch presents a valid instruction.
- `if_instrucao` in 32: fetched instruction.
- `if_pc4` in 32: PC+4 of that instruction.
- `if_ready` out 1: decode accepts this cycle; equals `!stall`.
- `stall` in 1: downstream hold request.
- `flush` in 1: kill the instruction held in ID.
- `id_valid` out 1: ID register holds a live instruction.
- `id_instrucao`, `id_pc4` out 32: registered copies.
- `opcode` out 6, `rs`/`rt`/`rd`/`shamt` out 5 each, `funct` out 6: instruction fields.
- `imm_ext` out 32: extended immediate.
- `jump`, `branch`, `branch_ne` out 1: PC-select controls.
- `jump_target` out 32: {id_pc4[31:28], instr[25:0], 2'b00}.
- `branch_target` out 32: id_pc4 + (imm_ext << 2), modulo 2^32.
- `reg_dst`, `alu_src`, `mem_to_reg`, `reg_write`, `mem_read`, `mem_write`, `link` out 1; `alu_op` out 2: control word.
- `ilegal` out 1: valid instruction with an unknown opcode.
- `cont_instr` out 32: count of retired (advanced, non-squashed) instructions.

## Operation
- Capture when `if_ready`, at posedge: `id_instrucao` <- `if_instrucao`, `id_pc4` <- `if_pc4`, `id_valid` <- `if_valid & !squash`.
- `squash` = `id_valid & jump`. The instruction fetched in the same cycle as a valid jump is sequential-path and is loaded as invalid, with `id_instrucao` <- `NOP`.
- `stall`=1: registers hold; `if_ready`=0.
- `flush`=1: `id_valid` <- 0 and `id_instrucao` <- `NOP`, regardless of `stall`. `flush` has priority over capture and stall.
- Decode is driven by the registered instruction. When `id_valid`=0, every control output, `ilegal`, `jump` and `branch` is 0. Field outputs still reflect the register.
- Opcode decode:
  - 000000 R-type: reg_dst, reg_write, alu_op=10.
  - 100011 lw: alu_src, mem_to_reg, reg_write, mem_read, alu_op=00.
  - 101011 sw: alu_src, mem_write, alu_op=00.
  - 000100 beq: branch, alu_op=01.
  - 000101 bne: branch, branch_ne, alu_op=01.
  - 001000 addi and 001010 slti: alu_src, reg_write, alu_op=00/11.
  - 001100 andi and 001101 ori: alu_src, reg_write, alu_op=11.
  - 000010 j: jump.
  - 000011 jal: jump, link, reg_write.
  - Anything else: `ilegal`=1, all controls 0.
- `imm_ext`: zero-extended for andi/ori; sign-extended from bit 15 otherwise.
- `cont_instr` increments when `id_valid & !stall & !flush`. It wraps from 2^32-1 to 0.

## Timing
- Reset (async) values:
  - `id_valid`=0, `id_instrucao`=`NOP`, `id_pc4`=0, `cont_instr`=0.
  - All control outputs 0; `if_ready`=`!stall`.
- Latency is 1 cycle from input capture to decoded outputs. Decode outputs are combinational from the registers, with no extra cycle.
- `jump`, `branch` and the targets are valid in the same cycle as `id_valid`. Fetch uses them at the next edge.
- Simultaneous `flush` and `stall`: flush wins; the next cycle has `id_valid`=0.
- Simultaneous `flush` and jump in ID: flush wins; the incoming instruction is also dropped and the counter does not increment.
- Reset asserted mid-stall: registers clear immediately.

## Structure
- Shared package: opcode and funct constants, `alu_op` encodings, `NOP`.
- One sub-module, `unidade_controle`: combinational opcode to control word, including `ilegal`.
- Extension and target adders stay inline.

## Test plan
- After reset: `id_valid`=0 and `cont_instr`=0. Then feed lw 0x8C220004 with pc4=0x04. The next cycle shows `alu_src`, `mem_read`, `mem_to_reg`, `reg_write` =1, `imm_ext`=0x4, rs=1, rt=2.
- beq 0x1000FFFF with pc4=0x10: `branch`=1, `branch_target`=0x0C. Repeat with andi imm 0xFFFF: `imm_ext`=0x0000FFFF.
- j 0x08000040 with pc4=0x24 and `if_valid`=1 next: `jump_target`=0x100. The instruction captured in the same cycle appears with `id_valid`=0 and `id_instrucao`=`NOP`; `cont_instr` skips it.
- Hold `stall` for 3 cycles with changing input: ID outputs are frozen and `if_ready`=0. After release, the counter has advanced exactly once for the held instruction.
- `flush` and `stall` together: next cycle `id_valid`=0 and all controls 0. Opcode 111111 valid gives `ilegal`=1 and `reg_write`=0.
- Async `reset` pulse mid-cycle while valid: outputs clear before the next edge.
